// File: rtl/trig_log_reader.sv
// trig_log_reader
//
// Consumer end of the trigger-timestamp data FIFO. Pops low/high 32-bit word
// pairs from a standard (non-FWFT) FIFO, reassembles them into 64-bit trigger
// timestamps, and presents each one with its delta from the previous
// timestamp and a running index on a valid/ready interface. Flags torn pairs
// (high word never arrived) and non-monotonic timestamps as sticky errors.
//
// Ports:
//   clk              block clock
//   rst              synchronous active-high reset
//   clear            synchronous soft clear of pairing state, index, prev ts
//   data_word_rd_en  FIFO pop (combinational)
//   data_word        FIFO read data, valid the cycle after a pop
//   data_buf_empty   FIFO empty
//   ts_valid         output timestamp valid
//   ts_ready         downstream accept
//   ts_value         reassembled timestamp {high, low}
//   ts_delta         ts_value - previous timestamp (0 for the first one)
//   ts_index         0-based index since reset/clear, wraps at 2^32
//   pair_err         sticky: high word missed the pairing timeout
//   order_err        sticky: a timestamp was below its predecessor
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a low word; pops when the FIFO is non-empty
// S_RD_LO   | popped low word is on data_word this cycle; capture it
// S_WAIT_HI | low held, waiting for the high word; timeout counting
// S_RD_HI   | popped high word is on data_word; build and register result
// S_OUT     | result presented, holding until ts_ready

module trig_log_reader #(
    parameter int unsigned PAIR_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    output logic        data_word_rd_en,
    input  logic [31:0] data_word,
    input  logic        data_buf_empty,
    output logic        ts_valid,
    input  logic        ts_ready,
    output logic [63:0] ts_value,
    output logic [63:0] ts_delta,
    output logic [31:0] ts_index,
    output logic        pair_err,
    output logic        order_err
);

    localparam int unsigned CNT_W = (PAIR_TIMEOUT == 0) ? 1 : $clog2(PAIR_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LO   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_RD_HI   = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t             state_q;
    logic [31:0]        lo_q;
    logic [CNT_W-1:0]   tmo_cnt_q;
    logic [63:0]        prev_q;
    logic               has_prev_q;
    logic [31:0]        idx_q;
    logic               ts_valid_q;
    logic [63:0]        ts_value_q;
    logic [63:0]        ts_delta_q;
    logic [31:0]        ts_index_q;
    logic               pair_err_q;
    logic               order_err_q;

    logic               pop;
    logic               tmo_hit;
    logic [63:0]        ts_new_d;
    logic [63:0]        ts_delta_d;
    logic               order_hit_d;

    // Pops only happen in the two states that are waiting for a word, so the
    // FIFO naturally backs up while a result sits unaccepted in S_OUT.
    assign pop = !rst && !clear && !data_buf_empty &&
                 (state_q == S_IDLE || state_q == S_WAIT_HI);
    assign data_word_rd_en = pop;

    assign tmo_hit     = (PAIR_TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(PAIR_TIMEOUT));
    assign ts_new_d    = {data_word, lo_q};
    assign ts_delta_d  = has_prev_q ? (ts_new_d - prev_q) : 64'd0;
    // Equality is allowed so a saturated counter repeating all-ones is not an error.
    assign order_hit_d = has_prev_q && (ts_new_d < prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            tmo_cnt_q   <= '0;
            prev_q      <= '0;
            has_prev_q  <= 1'b0;
            idx_q       <= '0;
            ts_valid_q  <= 1'b0;
            ts_value_q  <= '0;
            ts_delta_q  <= '0;
            ts_index_q  <= '0;
            pair_err_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else if (clear) begin
            // Any word already popped is dropped; sticky errors survive.
            state_q    <= S_IDLE;
            ts_valid_q <= 1'b0;
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    lo_q      <= data_word;
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // A high word arriving on the timeout cycle still wins.
                    if (pop) begin
                        state_q <= S_RD_HI;
                    end else if (tmo_hit) begin
                        pair_err_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                S_RD_HI: begin
                    ts_value_q <= ts_new_d;
                    ts_delta_q <= ts_delta_d;
                    ts_index_q <= idx_q;
                    if (order_hit_d) begin
                        order_err_q <= 1'b1;
                    end
                    prev_q     <= ts_new_d;
                    has_prev_q <= 1'b1;
                    idx_q      <= idx_q + 32'd1;
                    ts_valid_q <= 1'b1;
                    state_q    <= S_OUT;
                end
                S_OUT: begin
                    if (ts_ready) begin
                        ts_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ts_valid  = ts_valid_q;
    assign ts_value  = ts_value_q;
    assign ts_delta  = ts_delta_q;
    assign ts_index  = ts_index_q;
    assign pair_err  = pair_err_q;
    assign order_err = order_err_q;

endmodule

// File: tb/tb_trig_log_reader.sv
// Testbench for trig_log_reader: FIFO model feeding the reader, a monitor
// collecting accepted timestamps, and a reference model that derives the
// expected value/delta/index/error sequence from the pushed timestamps.

module tb_trig_log_reader;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        data_word_rd_en;
    logic [31:0] data_word;
    logic        data_buf_empty;
    logic        ts_valid;
    logic        ts_ready;
    logic [63:0] ts_value;
    logic [63:0] ts_delta;
    logic [31:0] ts_index;
    logic        pair_err;
    logic        order_err;

    int n_vec;
    int n_err;

    trig_log_reader #(.PAIR_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .data_word_rd_en (data_word_rd_en),
        .data_word       (data_word),
        .data_buf_empty  (data_buf_empty),
        .ts_valid        (ts_valid),
        .ts_ready        (ts_ready),
        .ts_value        (ts_value),
        .ts_delta        (ts_delta),
        .ts_index        (ts_index),
        .pair_err        (pair_err),
        .order_err       (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Standard FIFO: read data appears the cycle after rd_en.
    logic [31:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign data_buf_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (data_word_rd_en) begin
            data_word <= fifo_mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [63:0] v;
        logic [63:0] d;
        logic [31:0] i;
    } rec_t;

    rec_t got_q[$];
    int   got_cyc[$];
    rec_t exp_q[$];
    bit   mark_arm = 0;
    int   first_pop = -1;

    always @(negedge clk) begin
        if (!rst && ts_valid && ts_ready) begin
            got_q.push_back({ts_value, ts_delta, ts_index});
            got_cyc.push_back(cyc);
        end
        if (mark_arm && data_word_rd_en) begin
            first_pop = cyc;
            mark_arm  = 0;
        end
    end

    // Reference model: timestamps in arrival order since the last reset/clear.
    logic [63:0] m_prev;
    bit          m_has;
    logic [31:0] m_idx;
    bit          m_order;
    bit          m_pair;

    function automatic void model_clear();
        m_prev = '0;
        m_has  = 0;
        m_idx  = '0;
    endfunction

    function automatic void model_ts(input logic [63:0] v);
        rec_t r;
        r.v = v;
        r.d = m_has ? (v - m_prev) : 64'd0;
        r.i = m_idx;
        if (m_has && (v < m_prev)) m_order = 1;
        m_prev = v;
        m_has  = 1;
        m_idx  = m_idx + 32'd1;
        exp_q.push_back(r);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_pair(input logic [63:0] v, input bit modeled);
        push_word(v[31:0]);
        push_word(v[63:32]);
        if (modeled) model_ts(v);
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && got_q.size() < n; k++) tick(1);
        ok = (got_q.size() >= n);
    endtask

    task automatic start_scenario();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        tick(1);
        wr_ptr = rd_ptr;
        tick(2);
        rst = 1'b0;
        model_clear();
        m_order = 0;
        m_pair  = 0;
        start_scenario();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        ts_ready = 1'b1;
        tick(2);
        push_word(32'hDEAD_BEEF);
        #1;
        n_vec++; if (data_word_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b required 0", data_word_rd_en); end
        tick(1);
        n_vec++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", ts_valid); end
        n_vec++; if (ts_value !== 64'd0) begin n_err++; $display("FAIL reset_value: got %h required 0", ts_value); end
        n_vec++; if (ts_delta !== 64'd0) begin n_err++; $display("FAIL reset_delta: got %h required 0", ts_delta); end
        n_vec++; if (ts_index !== 32'd0) begin n_err++; $display("FAIL reset_index: got %h required 0", ts_index); end
        n_vec++; if (pair_err !== 1'b0) begin n_err++; $display("FAIL reset_pair_err: got %b required 0", pair_err); end
        n_vec++; if (order_err !== 1'b0) begin n_err++; $display("FAIL reset_order_err: got %b required 0", order_err); end
        n_vec++; if (rd_ptr !== 0) begin n_err++; $display("FAIL reset_no_pop: got rd_ptr %0d required 0", rd_ptr); end
        do_reset();
    endtask

    task automatic test_basic();
        bit ok;
        start_scenario();
        ts_ready  = 1'b1;
        first_pop = -1;
        mark_arm  = 1;
        push_pair(64'h0, 1);
        push_pair(64'h64, 1);
        wait_got(2, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_count: got %0d outputs required 2", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL basic_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", k,
                         got_q[k].v, got_q[k].d, got_q[k].i, exp_q[k].v, exp_q[k].d, exp_q[k].i);
            end
        end
        if (ok) begin
            n_vec++; if (got_cyc[0] != first_pop + 4) begin n_err++; $display("FAIL basic_latency: got cycle %0d required %0d", got_cyc[0], first_pop + 4); end
            n_vec++; if (got_cyc[1] != got_cyc[0] + 5) begin n_err++; $display("FAIL basic_throughput: got cycle %0d required %0d", got_cyc[1], got_cyc[0] + 5); end
        end
    endtask

    task automatic test_carry();
        bit ok;
        start_scenario();
        do_clear();
        push_pair(64'h0000_0000_FFFF_FFFF, 1);
        push_pair(64'h0000_0001_0000_0001, 1);
        wait_got(2, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL carry_count: got %0d outputs required 2", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL carry_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", k,
                         got_q[k].v, got_q[k].d, got_q[k].i, exp_q[k].v, exp_q[k].d, exp_q[k].i);
            end
        end
        n_vec++; if (order_err !== 1'b0) begin n_err++; $display("FAIL carry_order_err: got %b required 0", order_err); end
    endtask

    task automatic test_saturated();
        bit ok;
        start_scenario();
        push_pair(64'hFFFF_FFFF_FFFF_FFFF, 1);
        push_pair(64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_got(2, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL sat_count: got %0d outputs required 2", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL sat_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", k,
                         got_q[k].v, got_q[k].d, got_q[k].i, exp_q[k].v, exp_q[k].d, exp_q[k].i);
            end
        end
        n_vec++; if (order_err !== m_order) begin n_err++; $display("FAIL sat_order_err: got %b required %b", order_err, m_order); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int k;
        start_scenario();
        do_clear();
        ts_ready = 1'b0;
        push_pair(64'h0000_0010_0000_1000, 1);
        push_pair(64'h0000_0010_0000_2000, 1);
        push_pair(64'h0000_0011_0000_0000, 1);
        for (k = 0; k < 20 && !ts_valid; k++) tick(1);
        n_vec++; if (!ts_valid) begin n_err++; $display("FAIL bp_valid_timeout: got valid %b required 1", ts_valid); end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if ({ts_valid, ts_value, ts_delta, ts_index} !== {1'b1, exp_q[0].v, exp_q[0].d, exp_q[0].i}) begin
                n_err++;
                $display("FAIL bp_hold c%0d: got vld=%b v=%h d=%h i=%h required vld=1 v=%h d=%h i=%h", c,
                         ts_valid, ts_value, ts_delta, ts_index, exp_q[0].v, exp_q[0].d, exp_q[0].i);
            end
            n_vec++; if (data_word_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en c%0d: got %b required 0", c, data_word_rd_en); end
            tick(1);
        end
        n_vec++; if (wr_ptr - rd_ptr != 4) begin n_err++; $display("FAIL bp_fifo_level: got %0d required 4", wr_ptr - rd_ptr); end
        ts_ready = 1'b1;
        wait_got(3, 60, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_count: got %0d outputs required 3", got_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            n_vec++;
            if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
                n_err++;
                $display("FAIL bp_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", j,
                         got_q[j].v, got_q[j].d, got_q[j].i, exp_q[j].v, exp_q[j].d, exp_q[j].i);
            end
        end
    endtask

    task automatic test_torn();
        bit ok;
        int t0;
        int g;
        start_scenario();
        ts_ready = 1'b1;
        n_vec++; if (pair_err !== 1'b0) begin n_err++; $display("FAIL torn_pre_pair_err: got %b required 0", pair_err); end
        first_pop = -1;
        mark_arm  = 1;
        push_word(32'h1234_5678);
        tick(1);
        n_vec++; if (first_pop < 0) begin n_err++; $display("FAIL torn_pop: got no pop required one"); end
        t0 = first_pop;
        for (g = 0; g < 40 && cyc < t0 + int'(TMO) + 2; g++) tick(1);
        n_vec++; if (pair_err !== 1'b0) begin n_err++; $display("FAIL torn_early: got pair_err %b at cycle %0d required 0", pair_err, cyc - t0); end
        tick(1);
        m_pair = 1;
        n_vec++; if (pair_err !== 1'b1) begin n_err++; $display("FAIL torn_rise: got pair_err %b at cycle %0d required 1", pair_err, cyc - t0); end
        n_vec++; if (got_q.size() != 0 || ts_valid !== 1'b0) begin n_err++; $display("FAIL torn_no_output: got %0d outputs valid %b required 0 0", got_q.size(), ts_valid); end
        push_pair(64'h0000_0020_0000_0000, 1);
        wait_got(1, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL torn_count: got %0d outputs required 1", got_q.size()); end
        n_vec++;
        if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL torn_after: got v=%h d=%h i=%h required v=%h d=%h i=%h",
                     got_q[0].v, got_q[0].d, got_q[0].i, exp_q[0].v, exp_q[0].d, exp_q[0].i);
        end
    endtask

    task automatic test_clear_rd_hi();
        bit ok;
        int t0;
        int g;
        start_scenario();
        ts_ready  = 1'b1;
        first_pop = -1;
        mark_arm  = 1;
        push_pair(64'h0000_0099_0000_0099, 0);
        tick(1);
        n_vec++; if (first_pop < 0) begin n_err++; $display("FAIL clr_pop: got no pop required one"); end
        t0 = first_pop;
        for (g = 0; g < 10 && cyc < t0 + 3; g++) tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
        tick(8);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL clr_no_output: got %0d outputs required 0", got_q.size()); end
        n_vec++; if (pair_err !== m_pair) begin n_err++; $display("FAIL clr_pair_err: got %b required %b", pair_err, m_pair); end
        n_vec++; if (order_err !== m_order) begin n_err++; $display("FAIL clr_order_err: got %b required %b", order_err, m_order); end
        push_pair(64'h50, 1);
        wait_got(1, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL clr_count: got %0d outputs required 1", got_q.size()); end
        n_vec++;
        if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL clr_after: got v=%h d=%h i=%h required v=%h d=%h i=%h",
                     got_q[0].v, got_q[0].d, got_q[0].i, exp_q[0].v, exp_q[0].d, exp_q[0].i);
        end
    endtask

    task automatic test_nonmono();
        bit ok;
        start_scenario();
        n_vec++; if (order_err !== 1'b0) begin n_err++; $display("FAIL nm_pre: got order_err %b required 0", order_err); end
        do_clear();
        push_pair(64'h200, 1);
        push_pair(64'h100, 1);
        wait_got(2, 40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL nm_count: got %0d outputs required 2", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL nm_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", k,
                         got_q[k].v, got_q[k].d, got_q[k].i, exp_q[k].v, exp_q[k].d, exp_q[k].i);
            end
        end
        n_vec++; if (order_err !== 1'b1) begin n_err++; $display("FAIL nm_order_err: got %b required 1", order_err); end
        do_clear();
        start_scenario();
        push_pair(64'h300, 1);
        wait_got(1, 40, ok);
        tick(2);
        n_vec++; if (order_err !== 1'b1) begin n_err++; $display("FAIL nm_sticky: got %b required 1", order_err); end
    endtask

    task automatic test_rst_midop();
        int k;
        start_scenario();
        ts_ready = 1'b0;
        push_pair(64'h0000_0007_0000_0007, 0);
        for (k = 0; k < 20 && !ts_valid; k++) tick(1);
        rst = 1'b1;
        tick(1);
        n_vec++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b required 0", ts_valid); end
        n_vec++; if ({ts_value, ts_delta, ts_index} !== '0) begin n_err++; $display("FAIL rst_mid_regs: got v=%h d=%h i=%h required 0", ts_value, ts_delta, ts_index); end
        n_vec++; if ({pair_err, order_err} !== 2'b00) begin n_err++; $display("FAIL rst_mid_errs: got %b%b required 00", pair_err, order_err); end
        ts_ready = 1'b1;
        do_reset();
        tick(5);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rst_mid_no_output: got %0d outputs required 0", got_q.size()); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        int pushed;
        int sel;
        logic [63:0] last;
        logic [63:0] v;
        do_reset();
        pushed = 0;
        last = {32'($urandom), 32'($urandom_range(0, 1000))};
        for (int c = 0; c < 4000 && got_q.size() < N; c++) begin
            ts_ready = ($urandom_range(0, 3) != 0);
            if (pushed < N && $urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 15);
                if (sel == 0)      v = '1;
                else if (sel < 3)  v = last - 64'($urandom_range(1, 5000));
                else               v = last + 64'($urandom_range(0, 5000));
                push_pair(v, 1);
                last = v;
                pushed++;
            end
            tick(1);
        end
        ts_ready = 1'b1;
        tick(5);
        n_vec++; if (got_q.size() != N) begin n_err++; $display("FAIL rnd_count: got %0d outputs required %0d", got_q.size(), N); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL rnd_ts%0d: got v=%h d=%h i=%h required v=%h d=%h i=%h", k,
                         got_q[k].v, got_q[k].d, got_q[k].i, exp_q[k].v, exp_q[k].d, exp_q[k].i);
            end
        end
        n_vec++; if (order_err !== m_order) begin n_err++; $display("FAIL rnd_order_err: got %b required %b", order_err, m_order); end
        n_vec++; if (pair_err !== m_pair) begin n_err++; $display("FAIL rnd_pair_err: got %b required %b", pair_err, m_pair); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        ts_ready = 1'b0;
        m_order  = 0;
        m_pair   = 0;
        model_clear();
        test_reset();
        test_basic();
        test_carry();
        test_saturated();
        test_backpressure();
        test_torn();
        test_clear_rd_hi();
        test_nonmono();
        test_rst_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
